pll_lock_supervisor: RTL
========================

// Module: pll_lock_supervisor
// PURPOSE
//  Supervises the 300 MHz system PLL: drives its active-high reset, qualifies its async locked flag,
//  and releases a clean system reset only after sustained lock. Runs on the free-running 50 MHz refclk.
//  Retries PLL reset on lock timeout and flags permanent failure. Re-enters reset on any lock loss.
//  sys_rst_n is refclk-domain; each 300 MHz consumer re-synchronises it locally.
// PARAMETERS
//  RST_PULSE_CYCLES    16     refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT_CYCLES 50000  max refclk cycles in WAIT_LOCK before retry (1 ms @ 50 MHz)
//  STABLE_CYCLES       1024   consecutive synced-lock cycles required before release (>=1)
//  MAX_RETRIES         3      PLL reset retries after first attempt before FAIL
// PORTS
//  refclk        in   1  50 MHz reference clock, same net as PLL refclk
//  rst_n         in   1  synchronous active-low reset
//  pll_locked    in   1  PLL locked flag, asynchronous to refclk
//  pll_rst       out  1  active-high reset to PLL rst input
//  sys_rst_n     out  1  active-low system reset, low until lock qualified
//  ready         out  1  high in RUN only
//  fail          out  1  sticky; high in FAIL
//  retry_cnt     out  $clog2(MAX_RETRIES+1)  retries used in current bring-up
//  lock_loss_cnt out  8  saturating count of RUN->lock-loss events (see CONFIGURATION)
// BEHAVIOUR
//  - rst_n low (sampled on refclk): state=RESET_PLL, timer=0, pll_rst=1, sys_rst_n=0, ready=0,
//    fail=0, retry_cnt=0, lock_loss_cnt=0, sync flops=0. All outputs registered.
//  - pll_locked passes a 2-FF synchroniser -> locked_s (2-cycle latency); FSM uses locked_s only.
//  - RESET_PLL: pll_rst=1; after RST_PULSE_CYCLES cycles -> WAIT_LOCK, timer=0.
//  - WAIT_LOCK: pll_rst=0. locked_s=1 -> STABLE, timer=0. Else when timer==LOCK_TIMEOUT_CYCLES-1:
//    retry_cnt==MAX_RETRIES -> FAIL; else retry_cnt++ and -> RESET_PLL. Lock wins over timeout same cycle.
//  - STABLE: locked_s=0 -> WAIT_LOCK, timer=0 (timeout restarts, no retry charged).
//    timer==STABLE_CYCLES-1 with locked_s=1 -> RUN.
//  - RUN: sys_rst_n=1, ready=1 from first RUN cycle. locked_s=0 -> RESET_PLL next edge: sys_rst_n=0,
//    ready=0, retry_cnt=0, lock_loss_cnt++ (saturates at 255).
//  - FAIL: pll_rst=0, sys_rst_n=0, ready=0, fail=1; terminal until rst_n. Late lock ignored.
//  - Single shared timer, width $clog2(max(all cycle params)); cleared on every state change.
//  - rst_n mid-operation from any state returns to reset values on next edge; PLL is re-reset.
//  - Illegal state encodings recover to RESET_PLL.
// CONFIGURATION
//  PLL_SUP_LOSS_CNT_EN defined: lock_loss_cnt counter implemented as above.
//  Not defined: counter removed, lock_loss_cnt tied to 8'h00; all other behaviour identical.
// STRUCTURE
//  Package pll_sup_pkg: state enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL} (3-bit),
//    localparam LOSS_CNT_W=8, function for timer width.
//  Sub-module sync_2ff (1-bit, reset to 0) for pll_locked; FSM, timer, counters in top.
// TESTING (bench params: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, STABLE_CYCLES=8, MAX_RETRIES=2)
//  1 Release rst_n, assert pll_locked 10 cycles later -> pll_rst high 4 cycles; sys_rst_n/ready rise
//    exactly 2(sync)+8+1 cycles after pll_locked rises; retry_cnt=0.
//  2 pll_locked never rises -> 3 pll_rst pulses (4 cycles each, 20-cycle gaps), retry_cnt 0->1->2,
//    then fail=1, sys_rst_n=0, pll_rst=0 held; later pll_locked=1 has no effect.
//  3 In STABLE, drop pll_locked at count 5 for 1 cycle -> no RUN, WAIT_LOCK, no retry; relock -> RUN
//    after full 8 new stable cycles.
//  4 In RUN drop pll_locked -> sys_rst_n=0, ready=0 3 cycles later, new pll_rst pulse,
//    lock_loss_cnt=1 (0 with macro off), retry_cnt=0; relock -> RUN again.
//  5 Lock rising on same cycle timer hits 19 in WAIT_LOCK -> STABLE, retry_cnt unchanged.
//  6 Assert rst_n=0 for 1 cycle while in RUN -> all outputs at reset values next edge, full sequence reruns.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

  // Supervisor FSM state; plain 3-bit constants so older tools and netlists read the same encoding.
  typedef logic [2:0] pll_state_t;

  localparam pll_state_t StResetPll = 3'd0;
  localparam pll_state_t StWaitLock = 3'd1;
  localparam pll_state_t StStable   = 3'd2;
  localparam pll_state_t StRun      = 3'd3;
  localparam pll_state_t StFail     = 3'd4;

  // Width of the saturating lock-loss event counter.
  localparam int unsigned LOSS_CNT_W = 8;

  // Bits needed to hold values 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n < 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

  // Width of the single shared timer that serves all three timed states.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return cnt_width(m);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; synchronous active-low reset to 0.
module pll_lock_supervisor_sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the asynchronous level, then re-time it once more before use.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies the synchronised locked flag over a
// stable window, then releases the system reset. Retries the PLL on lock timeout, goes to a
// sticky fail state when retries run out, and re-resets the PLL on any lock loss while running.
// Optional feature: define PLL_SUP_LOSS_CNT_EN to implement the lock-loss event counter;
// without it lock_loss_cnt is tied to zero.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                                     refclk,
  input  logic                                     rst_n,
  input  logic                                     pll_locked,
  output logic                                     pll_rst,
  output logic                                     sys_rst_n,
  output logic                                     ready,
  output logic                                     fail,
  output logic [cnt_width(MAX_RETRIES + 1)-1:0]    retry_cnt,
  output logic [LOSS_CNT_W-1:0]                    lock_loss_cnt
);

  localparam int unsigned TimerW =
      timer_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);
  localparam int unsigned RetryW = cnt_width(MAX_RETRIES + 1);

  localparam logic [TimerW-1:0] RstLast    = TimerW'(RST_PULSE_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLast   = TimerW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] StableLast = TimerW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax   = RetryW'(MAX_RETRIES);

  pll_state_t        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              pll_rst_q;
  logic              sys_rst_n_q;
  logic              ready_q;
  logic              fail_q;
  logic              locked_s;

  pll_lock_supervisor_sync_2ff u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  // Next-state, shared timer and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    retry_d = retry_q;
    case (state_q)
      StResetPll: begin
        if (timer_q == RstLast) begin
          state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s) begin
          state_d = StStable;
        end else if (timer_q == LockLast) begin
          if (retry_q == RetryMax) begin
            state_d = StFail;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StResetPll;
          end
        end
      end
      StStable: begin
        // A glitch restarts the lock wait without charging a retry.
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (timer_q == StableLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        timer_d = '0;
        if (!locked_s) begin
          state_d = StResetPll;
          retry_d = '0;
        end
      end
      StFail: begin
        timer_d = '0;
      end
      default: begin
        state_d = StResetPll;
      end
    endcase
    // Every state change starts the timer from zero, including recovery from illegal codes.
    if (state_d != state_q) begin
      timer_d = '0;
    end
  end

  // State, timer, counters and registered outputs (decoded from next state so they align).
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= StResetPll;
      timer_q     <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == StResetPll);
      sys_rst_n_q <= (state_d == StRun);
      ready_q     <= (state_d == StRun);
      fail_q      <= (state_d == StFail);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

`ifdef PLL_SUP_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic                  loss_evt;

  assign loss_evt = (state_q == StRun) && !locked_s;

  // Saturating count of lock losses seen while running.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      loss_cnt_q <= '0;
    end else if (loss_evt && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule
